// File: rtl/obstacle_array_control.sv
// Multi-slot falling-obstacle controller: spawns obstacles at LFSR-driven X positions,
// retires them as catches or misses, and ramps fall speed with cumulative catches.
module obstacle_array_control #(
  parameter int unsigned  NUM_OBS          = 4,
  parameter logic [9:0]   OBSTACLE_WIDTH   = 10'd30,
  parameter logic [9:0]   SCREEN_W         = 10'd640,
  parameter logic [9:0]   SCREEN_H         = 10'd480,
  parameter logic [9:0]   BASE_SPEED       = 10'd4,
  parameter logic [9:0]   MAX_SPEED        = 10'd16,
  parameter logic [7:0]   SPAWN_INTERVAL   = 8'd32,
  parameter logic [7:0]   LEVEL_UP_CATCHES = 8'd8,
  parameter logic [15:0]  LFSR_SEED        = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_en,
  input  logic                  run,
  input  logic [NUM_OBS-1:0]    collision,
  output logic [NUM_OBS-1:0]    obs_active,
  output logic [NUM_OBS*10-1:0] obs_x,
  output logic [NUM_OBS*10-1:0] obs_y,
  output logic [9:0]            speed,
  output logic                  catch_pulse,
  output logic                  miss_pulse,
  output logic [15:0]           catch_count
);

  localparam logic [9:0] X_LIM    = SCREEN_W - OBSTACLE_WIDTH;
  localparam logic [9:0] X_WRAP   = X_LIM + 10'd1;
  localparam logic [7:0] SPAWN_TC = SPAWN_INTERVAL - 8'd1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    sat_add16 = s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [9:0] speed_inc(input logic [9:0] s);
    speed_inc = (s >= MAX_SPEED) ? MAX_SPEED : s + 10'd1;
  endfunction

  // Fold LFSR values past the right edge back into the visible span
  function automatic logic [9:0] spawn_x(input logic [9:0] v);
    spawn_x = (v <= X_LIM) ? v : v - X_WRAP;
  endfunction

  logic [15:0]           lfsr;
  logic [7:0]            spawn_cnt;
  logic [15:0]           lvl_acc;

  logic                  tick;
  logic [NUM_OBS-1:0]    act_nxt;
  logic [NUM_OBS*10-1:0] x_nxt;
  logic [NUM_OBS*10-1:0] y_nxt;
  logic [NUM_OBS-1:0]    catch_vec;
  logic [NUM_OBS-1:0]    miss_vec;
  logic [3:0]            n_catch;
  logic                  spawn_due;
  logic                  spawned;
  logic [10:0]           y_sum;
  logic [7:0]            cnt_nxt;
  logic [15:0]           acc_sum;
  logic [15:0]           acc_nxt;
  logic [9:0]            speed_nxt;
  logic [15:0]           cc_nxt;

  assign tick = game_en & run;

  always_comb begin
    act_nxt   = obs_active;
    x_nxt     = obs_x;
    y_nxt     = obs_y;
    catch_vec = '0;
    miss_vec  = '0;
    n_catch   = 4'd0;
    spawned   = 1'b0;
    y_sum     = 11'd0;
    spawn_due = (spawn_cnt == SPAWN_TC);
    for (int i = 0; i < int'(NUM_OBS); i++) begin
      y_sum = {1'b0, obs_y[i*10 +: 10]} + {1'b0, speed};
      if (obs_active[i]) begin
        if (collision[i]) begin
          act_nxt[i]         = 1'b0;
          x_nxt[i*10 +: 10]  = 10'd0;
          y_nxt[i*10 +: 10]  = 10'd0;
          catch_vec[i]       = 1'b1;
          n_catch            = n_catch + 4'd1;
        end else if (y_sum >= {1'b0, SCREEN_H}) begin
          act_nxt[i]         = 1'b0;
          x_nxt[i*10 +: 10]  = 10'd0;
          y_nxt[i*10 +: 10]  = 10'd0;
          miss_vec[i]        = 1'b1;
        end else begin
          y_nxt[i*10 +: 10]  = y_sum[9:0];
        end
      end else if (spawn_due && !spawned) begin
        // Only slots free at the start of the tick are candidates
        act_nxt[i]           = 1'b1;
        x_nxt[i*10 +: 10]    = spawn_x(lfsr[9:0]);
        y_nxt[i*10 +: 10]    = 10'd0;
        spawned              = 1'b1;
      end
    end

    if (spawn_due) cnt_nxt = spawned ? 8'd0 : spawn_cnt;
    else           cnt_nxt = spawn_cnt + 8'd1;

    acc_sum   = sat_add16(lvl_acc, n_catch);
    acc_nxt   = acc_sum;
    speed_nxt = speed;
    if (acc_sum >= {8'd0, LEVEL_UP_CATCHES}) begin
      acc_nxt   = acc_sum - {8'd0, LEVEL_UP_CATCHES};
      speed_nxt = speed_inc(speed);
    end
    cc_nxt = sat_add16(catch_count, n_catch);
  end

  // Stage p0: registered game state and event pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr        <= LFSR_SEED;
      spawn_cnt   <= 8'd0;
      lvl_acc     <= 16'd0;
      obs_active  <= '0;
      obs_x       <= '0;
      obs_y       <= '0;
      speed       <= BASE_SPEED;
      catch_count <= 16'd0;
      catch_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      if (game_en) lfsr <= lfsr_step(lfsr);
      if (tick) begin
        spawn_cnt   <= cnt_nxt;
        lvl_acc     <= acc_nxt;
        obs_active  <= act_nxt;
        obs_x       <= x_nxt;
        obs_y       <= y_nxt;
        speed       <= speed_nxt;
        catch_count <= cc_nxt;
        catch_pulse <= |catch_vec;
        miss_pulse  <= |miss_vec;
      end else begin
        catch_pulse <= 1'b0;
        miss_pulse  <= 1'b0;
      end
    end
  end

endmodule
